// File: rtl/hdmi_i2c_pkg.sv
// hdmi_i2c_pkg: types and widths shared by the HDMI/config I2C master and target.
package hdmi_i2c_pkg;
   localparam int ADDR_W = 16;
   localparam int DATA_W = 16;
   typedef enum logic [3:0] {
      IDLE, ADDR, ACK_ADDR, REG_H, ACK_RH, REG_L, ACK_RL,
      WR_H, ACK_WH, WR_L, ACK_WL, RD_H, MACK_H, RD_L, MACK_L
   } state_t;
   typedef enum logic [1:0] {EV_NONE, EV_START, EV_STOP} ev_t;
   function automatic logic is_bit_state(state_t s);
      return s inside {ADDR, REG_H, REG_L, WR_H, WR_L, RD_H, RD_L};
   endfunction
endpackage

// File: rtl/i2c_in_filter.sv
// i2c_in_filter: synchronizes an asynchronous I2C pin and accepts a new level
// only after it has been stable for FILT cycles; rise/fall pulse with the update.
module i2c_in_filter #(
   parameter int FILT = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);
   localparam int CW = $clog2(FILT + 1);
   logic [1:0] sync;
   logic [CW-1:0] cnt;
   logic upd;
   assign upd = sync[1] != q && cnt == CW'(FILT - 1);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync <= 2'b11;
         cnt <= '0;
         q <= 1'b1;
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         sync <= {sync[0], d};
         cnt <= (sync[1] == q || upd) ? '0 : cnt + 1'b1;
         if (upd) q <= sync[1];
         rise <= upd && sync[1];
         fall <= upd && !sync[1];
      end
   end
endmodule

// File: rtl/hdmi_i2c_slave.sv
// hdmi_i2c_slave: I2C target for 16-bit register / 16-bit data transactions,
// bridged to a synchronous register-port handshake.
module hdmi_i2c_slave import hdmi_i2c_pkg::*; #(
   parameter logic [6:0] DEV_ADDR = 7'h39,
   parameter int         FILT     = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              scl_i,
   input  logic              sda_i,
   output logic              sda_oe,
   output logic [ADDR_W-1:0] reg_addr,
   output logic [DATA_W-1:0] reg_wdata,
   output logic              reg_wr,
   output logic              reg_rd,
   input  logic [DATA_W-1:0] reg_rdata,
   output logic              busy
);
   logic scl_f, scl_rise, scl_fall, sda_f, sda_rise, sda_fall;
   logic oe, mack, rd_go;
   logic [1:0] rd_pend;
   logic [3:0] cnt;
   logic [7:0] sh, hold, lo;
   logic [6:0] tx;
   ev_t ev;
   state_t state, state_n;

   i2c_in_filter #(.FILT(FILT)) u_scl (.clk(clk), .rst_n(rst_n), .d(scl_i), .q(scl_f), .rise(scl_rise), .fall(scl_fall));
   i2c_in_filter #(.FILT(FILT)) u_sda (.clk(clk), .rst_n(rst_n), .d(sda_i), .q(sda_f), .rise(sda_rise), .fall(sda_fall));

   assign ev = !scl_f ? EV_NONE : sda_fall ? EV_START : sda_rise ? EV_STOP : EV_NONE;
   // a bus event releases SDA in the same cycle it is seen
   assign sda_oe = oe && ev == EV_NONE;

   always_comb begin
      state_n = state;
      if (ev == EV_START) state_n = ADDR;
      else if (ev == EV_STOP) state_n = IDLE;
      else if (scl_fall) begin
         if (is_bit_state(state)) begin
            if (cnt == 4'd8) state_n = (state == ADDR && sh[7:1] != DEV_ADDR) ? IDLE : state_t'(state + 4'd1);
         end else if (state == ACK_ADDR) state_n = sh[0] ? RD_H : REG_H;
         else if (state == ACK_WL) state_n = WR_H;
         else if (state == MACK_H || state == MACK_L) state_n = mack ? IDLE : state == MACK_H ? RD_L : RD_H;
         else if (state != IDLE) state_n = state_t'(state + 4'd1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt <= '0;
         sh <= '0;
         hold <= '0;
         lo <= '0;
         tx <= '0;
         mack <= 1'b1;
         oe <= 1'b0;
         busy <= 1'b0;
         rd_go <= 1'b0;
         rd_pend <= '0;
         reg_addr <= '0;
         reg_wdata <= '0;
         reg_wr <= 1'b0;
         reg_rd <= 1'b0;
      end else begin
         state <= state_n;
         reg_wr <= 1'b0;
         rd_go <= 1'b0;
         reg_rd <= rd_go;
         rd_pend <= {rd_pend[0], reg_rd};
         if (reg_wr) reg_addr <= reg_addr + 1'b1;
         if (state_n != state || ev != EV_NONE) cnt <= '0;
         else if (scl_rise && is_bit_state(state)) cnt <= cnt + 4'd1;
         if (scl_rise) begin
            mack <= sda_f;
            if (is_bit_state(state)) sh <= {sh[6:0], sda_f};
         end
         if (ev != EV_NONE) begin
            oe <= 1'b0;
            busy <= 1'b0;
         end else if (rd_pend[1] && state == RD_H) begin
            // read word arrives a few cycles into the SCL-low phase; drive its MSB now
            tx <= reg_rdata[14:8];
            lo <= reg_rdata[7:0];
            oe <= !reg_rdata[15];
         end else if (scl_fall) begin
            case (state)
               ADDR: if (cnt == 4'd8) begin
                  oe <= state_n == ACK_ADDR;
                  busy <= state_n == ACK_ADDR;
               end
               REG_H, REG_L, WR_H: if (cnt == 4'd8) begin
                  oe <= 1'b1;
                  hold <= sh;
                  if (state == REG_L) reg_addr <= {hold, sh};
               end
               WR_L: if (cnt == 4'd8) begin
                  oe <= 1'b1;
                  reg_wdata <= {hold, sh};
               end
               RD_H, RD_L: begin
                  oe <= cnt != 4'd8 && !tx[6];
                  tx <= {tx[5:0], 1'b0};
               end
               ACK_ADDR: begin
                  oe <= 1'b0;
                  rd_go <= sh[0];
               end
               ACK_WL: begin
                  oe <= 1'b0;
                  reg_wr <= 1'b1;
               end
               MACK_H: begin
                  oe <= !mack && !lo[7];
                  tx <= lo[6:0];
                  busy <= !mack;
               end
               MACK_L: begin
                  oe <= 1'b0;
                  busy <= !mack;
                  if (!mack) begin
                     reg_addr <= reg_addr + 1'b1;
                     rd_go <= 1'b1;
                  end
               end
               default: oe <= 1'b0;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_hdmi_i2c_slave.sv
// tb_hdmi_i2c_slave: bit-banged I2C master with an open-drain bus model and
// strobe/byte scoreboards for hdmi_i2c_slave.
module tb_hdmi_i2c_slave;
   localparam int Q = 20;
   logic clk = 0, rst_n = 0, scl = 1, sda_m = 1, sda_line;
   logic sda_oe, reg_wr, reg_rd, busy;
   logic [15:0] reg_addr, reg_wdata;
   logic [15:0] reg_rdata = 16'h0;
   logic [15:0] mem [logic [15:0]];
   logic [31:0] got_wr[$], exp_wr[$];
   logic [15:0] got_rd[$], exp_rd[$];
   logic [7:0] exp_byte[$];
   logic oe_seen = 0;
   int total = 0, bad = 0;

   assign sda_line = sda_m & ~sda_oe;
   always #5 clk = ~clk;

   hdmi_i2c_slave #(.DEV_ADDR(7'h39), .FILT(3)) dut (
      .clk(clk), .rst_n(rst_n), .scl_i(scl), .sda_i(sda_line), .sda_oe(sda_oe),
      .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wr(reg_wr), .reg_rd(reg_rd),
      .reg_rdata(reg_rdata), .busy(busy));

   always @(posedge clk) if (reg_rd) reg_rdata <= mem.exists(reg_addr) ? mem[reg_addr] : 16'h0;

   always @(negedge clk) begin
      if (reg_wr) got_wr.push_back({reg_addr, reg_wdata});
      if (reg_rd) got_rd.push_back(reg_addr);
      if (sda_oe) oe_seen = 1'b1;
   end

   task automatic w(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic start_c();
      sda_m = 1; w(Q); scl = 1; w(Q); sda_m = 0; w(Q); scl = 0; w(Q);
   endtask

   task automatic stop_c();
      sda_m = 0; w(Q); scl = 1; w(Q); sda_m = 1; w(Q);
   endtask

   task automatic bit_c(input logic b, input logic g, output logic s);
      sda_m = b; w(Q); scl = 1; w(Q / 2);
      if (g) begin
         sda_m = 0; w(1); sda_m = 1;
      end
      w(Q / 2); s = sda_line; w(Q); scl = 0; w(Q);
   endtask

   task automatic send_byte(input logic [7:0] b, input int g, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) bit_c(b[i], i == g, s);
      bit_c(1'b1, 1'b0, ack);
   endtask

   task automatic recv_byte(input logic mk, output logic [7:0] b);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         bit_c(1'b1, 1'b0, s);
         b[i] = s;
      end
      bit_c(mk, 1'b0, s);
   endtask

   task automatic test_reset();
      w(5);
      total++; if (sda_oe !== 1'b0) begin bad++; $display("FAIL rst_sda_oe got=%b exp=0", sda_oe); end
      total++; if (reg_addr !== 16'h0) begin bad++; $display("FAIL rst_reg_addr got=%h exp=0000", reg_addr); end
      total++; if (reg_wdata !== 16'h0) begin bad++; $display("FAIL rst_reg_wdata got=%h exp=0000", reg_wdata); end
      total++; if ({reg_wr, reg_rd, busy} !== 3'b000) begin bad++; $display("FAIL rst_strobes got=%b exp=000", {reg_wr, reg_rd, busy}); end
      rst_n = 1; w(Q);
   endtask

   task automatic test_write();
      logic [7:0] bs [5] = '{8'h72, 8'h12, 8'h34, 8'hAB, 8'hCD};
      logic a;
      logic [31:0] e, g;
      exp_wr.push_back({16'h1234, 16'hABCD});
      start_c();
      for (int i = 0; i < 5; i++) begin
         send_byte(bs[i], -1, a);
         total++; if (a !== 1'b0) begin bad++; $display("FAIL write_ack%0d got=%b exp=0", i, a); end
      end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL write_busy got=%b exp=1", busy); end
      stop_c(); w(Q);
      while (exp_wr.size() > 0) begin
         e = exp_wr.pop_front(); g = got_wr.size() > 0 ? got_wr.pop_front() : 32'hx;
         total++; if (g !== e) begin bad++; $display("FAIL write_strobe got=%h exp=%h", g, e); end
      end
      total++; if (got_wr.size() != 0) begin bad++; $display("FAIL write_extra got=%0d exp=0", got_wr.size()); got_wr.delete(); end
      total++; if (reg_addr !== 16'h1235) begin bad++; $display("FAIL write_ptr got=%h exp=1235", reg_addr); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL write_busy_end got=%b exp=0", busy); end
   endtask

   task automatic test_read();
      logic [7:0] bs [3] = '{8'h72, 8'h00, 8'h10};
      logic a;
      logic [7:0] b, e;
      logic [15:0] ea, ga;
      mem[16'h0010] = 16'h5AA5;
      mem[16'h0011] = 16'h1234;
      exp_rd.push_back(16'h0010); exp_rd.push_back(16'h0011);
      exp_byte.push_back(8'h5A); exp_byte.push_back(8'hA5); exp_byte.push_back(8'h12); exp_byte.push_back(8'h34);
      start_c();
      for (int i = 0; i < 3; i++) begin
         send_byte(bs[i], -1, a);
         total++; if (a !== 1'b0) begin bad++; $display("FAIL read_setup_ack%0d got=%b exp=0", i, a); end
      end
      start_c();
      send_byte(8'h73, -1, a);
      total++; if (a !== 1'b0) begin bad++; $display("FAIL read_addr_ack got=%b exp=0", a); end
      for (int k = 0; k < 4; k++) begin
         recv_byte(k == 3, b);
         e = exp_byte.pop_front();
         total++; if (b !== e) begin bad++; $display("FAIL read_byte%0d got=%h exp=%h", k, b, e); end
      end
      w(5);
      total++; if (sda_oe !== 1'b0) begin bad++; $display("FAIL read_nack_release got=%b exp=0", sda_oe); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL read_nack_busy got=%b exp=0", busy); end
      stop_c(); w(Q);
      while (exp_rd.size() > 0) begin
         ea = exp_rd.pop_front(); ga = got_rd.size() > 0 ? got_rd.pop_front() : 16'hx;
         total++; if (ga !== ea) begin bad++; $display("FAIL read_strobe got=%h exp=%h", ga, ea); end
      end
      total++; if (got_rd.size() != 0 || got_wr.size() != 0) begin bad++; $display("FAIL read_extra got=%0d/%0d exp=0/0", got_rd.size(), got_wr.size()); got_rd.delete(); got_wr.delete(); end
      total++; if (reg_addr !== 16'h0011) begin bad++; $display("FAIL read_ptr got=%h exp=0011", reg_addr); end
   endtask

   task automatic test_wrong_addr();
      logic a;
      oe_seen = 1'b0;
      start_c();
      send_byte(8'h50, -1, a);
      total++; if (a !== 1'b1) begin bad++; $display("FAIL wrong_addr_nack got=%b exp=1", a); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL wrong_addr_busy got=%b exp=0", busy); end
      send_byte(8'h12, -1, a);
      total++; if (a !== 1'b1) begin bad++; $display("FAIL wrong_addr_ignore got=%b exp=1", a); end
      stop_c(); w(Q);
      total++; if (oe_seen !== 1'b0) begin bad++; $display("FAIL wrong_addr_oe got=%b exp=0", oe_seen); end
      total++; if (got_wr.size() + got_rd.size() != 0) begin bad++; $display("FAIL wrong_addr_strobes got=%0d exp=0", got_wr.size() + got_rd.size()); got_wr.delete(); got_rd.delete(); end
   endtask

   task automatic test_burst_wrap();
      logic [7:0] bs [7] = '{8'h72, 8'hFF, 8'hFF, 8'h11, 8'h22, 8'h33, 8'h44};
      logic a;
      logic [31:0] e, g;
      exp_wr.push_back({16'hFFFF, 16'h1122});
      exp_wr.push_back({16'h0000, 16'h3344});
      start_c();
      for (int i = 0; i < 7; i++) begin
         send_byte(bs[i], -1, a);
         total++; if (a !== 1'b0) begin bad++; $display("FAIL burst_ack%0d got=%b exp=0", i, a); end
      end
      stop_c(); w(Q);
      while (exp_wr.size() > 0) begin
         e = exp_wr.pop_front(); g = got_wr.size() > 0 ? got_wr.pop_front() : 32'hx;
         total++; if (g !== e) begin bad++; $display("FAIL burst_strobe got=%h exp=%h", g, e); end
      end
      total++; if (got_wr.size() != 0) begin bad++; $display("FAIL burst_extra got=%0d exp=0", got_wr.size()); got_wr.delete(); end
      total++; if (reg_addr !== 16'h0001) begin bad++; $display("FAIL burst_ptr got=%h exp=0001", reg_addr); end
   endtask

   task automatic test_stop_mid();
      logic [7:0] bs [4] = '{8'h72, 8'h00, 8'h20, 8'hAB};
      logic a;
      start_c();
      for (int i = 0; i < 4; i++) send_byte(bs[i], -1, a);
      stop_c(); w(Q);
      total++; if (got_wr.size() != 0) begin bad++; $display("FAIL stop_mid_wr got=%0d exp=0", got_wr.size()); got_wr.delete(); end
      total++; if (reg_addr !== 16'h0020) begin bad++; $display("FAIL stop_mid_ptr got=%h exp=0020", reg_addr); end
   endtask

   task automatic test_glitch();
      logic [7:0] bs [5] = '{8'h72, 8'h00, 8'h30, 8'h55, 8'h66};
      logic a;
      logic [31:0] e, g;
      exp_wr.push_back({16'h0030, 16'h5566});
      start_c();
      for (int i = 0; i < 5; i++) begin
         send_byte(bs[i], i == 2 ? 5 : -1, a);
         total++; if (a !== 1'b0) begin bad++; $display("FAIL glitch_ack%0d got=%b exp=0", i, a); end
      end
      stop_c(); w(Q);
      while (exp_wr.size() > 0) begin
         e = exp_wr.pop_front(); g = got_wr.size() > 0 ? got_wr.pop_front() : 32'hx;
         total++; if (g !== e) begin bad++; $display("FAIL glitch_strobe got=%h exp=%h", g, e); end
      end
      total++; if (got_wr.size() != 0) begin bad++; $display("FAIL glitch_extra got=%0d exp=0", got_wr.size()); got_wr.delete(); end
   endtask

   task automatic test_reset_mid_ack();
      logic [7:0] b = 8'h72;
      logic s;
      start_c();
      for (int i = 7; i >= 0; i--) bit_c(b[i], 1'b0, s);
      total++; if (sda_oe !== 1'b1) begin bad++; $display("FAIL mid_ack_drive got=%b exp=1", sda_oe); end
      #3 rst_n = 0;
      #1;
      total++; if (sda_oe !== 1'b0) begin bad++; $display("FAIL async_rst_oe got=%b exp=0", sda_oe); end
      total++; if ({reg_addr, reg_wdata} !== 32'h0) begin bad++; $display("FAIL async_rst_regs got=%h exp=00000000", {reg_addr, reg_wdata}); end
      total++; if ({reg_wr, reg_rd, busy} !== 3'b000) begin bad++; $display("FAIL async_rst_strobes got=%b exp=000", {reg_wr, reg_rd, busy}); end
      scl = 1; sda_m = 1; w(5);
      rst_n = 1; w(Q);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_write();
      test_read();
      test_wrong_addr();
      test_burst_wrap();
      test_stop_mid();
      test_glitch();
      test_reset_mid_ack();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
